// File: rtl/stage_e_mdu.sv
// Execute stage: D->E register, operand forwarding, single-cycle ALU and an
// iterative multiply/divide unit that is built only when STAGE_E_MDU_EN is defined.
module stage_e_mdu #(
    parameter int XLEN = 32,
    parameter int REGW = 5,
    parameter int CNTW = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] Rd1D,
    input  logic [XLEN-1:0] Rd2D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [REGW-1:0] RdD,
    input  logic [REGW-1:0] Rs1D,
    input  logic [REGW-1:0] Rs2D,
    input  logic            RegWriteD,
    input  logic            MemWriteD,
    input  logic            ALUSrcD,
    input  logic [1:0]      ResultSrcD,
    input  logic [3:0]      OpD,
    input  logic            SignedD,
    input  logic            FlushE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] ResultW,
    output logic [REGW-1:0] RdE,
    output logic [REGW-1:0] Rs1E,
    output logic [REGW-1:0] Rs2E,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic [1:0]      ResultSrcE,
    output logic [XLEN-1:0] ALUResultE,
    output logic [XLEN-1:0] WriteDataE,
    output logic            StallReqE,
    output logic            MduBusyE
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2;
    localparam logic [3:0] OP_OR = 4'd3, OP_XOR = 4'd4, OP_SLT = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6, OP_SLL = 4'd7, OP_SRL = 4'd8;
    localparam logic [3:0] OP_SRA = 4'd9, OP_MUL = 4'd10, OP_MULH = 4'd11;
    localparam logic [3:0] OP_DIV = 4'd13, OP_REM = 4'd14;
    localparam logic [3:0] OP_MULHSU = 4'd15;

    logic [XLEN-1:0] r_Rd1E, r_Rd2E, r_ImmExtE;
    logic [REGW-1:0] r_RdE, r_Rs1E, r_Rs2E;
    logic            r_RegWriteE, r_MemWriteE, r_ALUSrcE, r_SignedE;
    logic [1:0]      r_ResultSrcE;
    logic [3:0]      r_OpE;
    logic            w_stall;
    logic [XLEN-1:0] w_op1, w_op2, w_wd, w_alu;
    logic [SHW-1:0]  w_shamt;

    // Flush beats stall: a bubble always replaces whatever E held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_Rd1E <= '0; r_Rd2E <= '0; r_ImmExtE <= '0;
            r_RdE <= '0; r_Rs1E <= '0; r_Rs2E <= '0;
            r_RegWriteE <= 1'b0; r_MemWriteE <= 1'b0;
            r_ALUSrcE <= 1'b0; r_SignedE <= 1'b0;
            r_ResultSrcE <= '0; r_OpE <= OP_ADD;
        end else if (FlushE) begin
            r_Rd1E <= '0; r_Rd2E <= '0; r_ImmExtE <= '0;
            r_RdE <= '0; r_Rs1E <= '0; r_Rs2E <= '0;
            r_RegWriteE <= 1'b0; r_MemWriteE <= 1'b0;
            r_ALUSrcE <= 1'b0; r_SignedE <= 1'b0;
            r_ResultSrcE <= '0; r_OpE <= OP_ADD;
        end else if (!w_stall) begin
            r_Rd1E <= Rd1D; r_Rd2E <= Rd2D; r_ImmExtE <= ImmExtD;
            r_RdE <= RdD; r_Rs1E <= Rs1D; r_Rs2E <= Rs2D;
            r_RegWriteE <= RegWriteD; r_MemWriteE <= MemWriteD;
            r_ALUSrcE <= ALUSrcD; r_SignedE <= SignedD;
            r_ResultSrcE <= ResultSrcD; r_OpE <= OpD;
        end
    end

    always_comb begin
        unique case (ForwardAE)
            2'b01:   w_op1 = ResultW;
            2'b10:   w_op1 = ALUResultM;
            default: w_op1 = r_Rd1E;
        endcase
        unique case (ForwardBE)
            2'b01:   w_wd = ResultW;
            2'b10:   w_wd = ALUResultM;
            default: w_wd = r_Rd2E;
        endcase
    end

    assign w_op2   = r_ALUSrcE ? r_ImmExtE : w_wd;
    assign w_shamt = w_op2[SHW-1:0];

    always_comb begin
        w_alu = '0;
        unique case (r_OpE)
            OP_ADD:  w_alu = w_op1 + w_op2;
            OP_SUB:  w_alu = w_op1 - w_op2;
            OP_AND:  w_alu = w_op1 & w_op2;
            OP_OR:   w_alu = w_op1 | w_op2;
            OP_XOR:  w_alu = w_op1 ^ w_op2;
            OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, $signed(w_op1) < $signed(w_op2)};
            OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, w_op1 < w_op2};
            OP_SLL:  w_alu = w_op1 << w_shamt;
            OP_SRL:  w_alu = w_op1 >> w_shamt;
            OP_SRA:  w_alu = $signed(w_op1) >>> w_shamt;
            default: w_alu = '0;
        endcase
    end

`ifdef STAGE_E_MDU_EN
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
    state_e            r_state, w_state_nx;
    logic [CNTW-1:0]   r_cnt;
    logic [2*XLEN-1:0] r_p, w_mul_nx, w_div_nx, w_prod;
    logic [2*XLEN:0]   w_sh;
    logic [XLEN:0]     w_sum, w_diff;
    logic [XLEN-1:0]   r_b, w_amag, w_bmag, w_lo, w_hi, w_q, w_r, w_mdu;
    logic              r_div, r_rem, r_hi, r_neg, r_dz;
    logic              w_is_mdu, w_isdiv, w_sa, w_sb, w_an, w_bn;

    assign w_is_mdu = r_OpE >= OP_MUL;
    assign w_isdiv  = (r_OpE == OP_DIV) || (r_OpE == OP_REM);
    assign w_sa = (r_OpE == OP_MULH) || (r_OpE == OP_MULHSU) || (w_isdiv && r_SignedE);
    assign w_sb = (r_OpE == OP_MULH) || (w_isdiv && r_SignedE);
    assign w_an = w_sa & w_op1[XLEN-1];
    assign w_bn = w_sb & w_op2[XLEN-1];
    assign w_amag = w_an ? -w_op1 : w_op1;
    assign w_bmag = w_bn ? -w_op2 : w_op2;

    // Unsigned radix-2 steps on magnitudes; r_p holds {hi/rem, lo/quotient}.
    assign w_sum    = {1'b0, r_p[2*XLEN-1:XLEN]} + (r_p[0] ? {1'b0, r_b} : '0);
    assign w_mul_nx = {w_sum, r_p[XLEN-1:1]};
    assign w_sh     = {r_p, 1'b0};
    assign w_diff   = w_sh[2*XLEN:XLEN] - {1'b0, r_b};
    assign w_div_nx = w_diff[XLEN] ? w_sh[2*XLEN-1:0]
                                   : {w_diff[XLEN-1:0], w_sh[XLEN-1:1], 1'b1};

    assign w_prod = r_neg ? -r_p : r_p;
    assign w_lo   = r_p[XLEN-1:0];
    assign w_hi   = r_p[2*XLEN-1:XLEN];
    assign w_q    = r_dz ? {XLEN{1'b1}} : (r_neg ? -w_lo : w_lo);
    assign w_r    = r_neg ? -w_hi : w_hi;
    assign w_mdu  = r_rem ? w_r : r_div ? w_q
                  : r_hi ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];

    always_comb begin
        w_state_nx = r_state;
        w_stall    = 1'b0;
        unique case (r_state)
            S_IDLE: if (w_is_mdu) begin
                w_stall = 1'b1;
                if (!FlushE) w_state_nx = S_BUSY;
            end
            S_BUSY: begin
                w_stall = 1'b1;
                if (FlushE) w_state_nx = S_IDLE;
                else if (r_cnt == '0) w_state_nx = S_DONE;
            end
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE; r_cnt <= '0; r_p <= '0; r_b <= '0;
            r_div <= 1'b0; r_rem <= 1'b0; r_hi <= 1'b0;
            r_neg <= 1'b0; r_dz <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            if (r_state == S_IDLE && w_is_mdu && !FlushE) begin
                r_p   <= {{XLEN{1'b0}}, w_amag};
                r_b   <= w_bmag;
                r_cnt <= CNTW'(XLEN-1);
                r_div <= w_isdiv;
                r_rem <= r_OpE == OP_REM;
                r_hi  <= r_OpE != OP_MUL;
                r_neg <= (r_OpE == OP_REM) ? w_an : (w_an ^ w_bn);
                r_dz  <= w_op2 == '0;
            end else if (r_state == S_BUSY) begin
                r_p   <= r_div ? w_div_nx : w_mul_nx;
                r_cnt <= r_cnt - CNTW'(1);
            end
        end
    end

    assign MduBusyE   = r_state != S_IDLE;
    assign ALUResultE = (r_state == S_DONE) ? w_mdu : w_alu;
`else
    logic            w_unused_sgn;
    logic [CNTW-1:0] w_unused_cnt;

    assign w_unused_sgn = r_SignedE;
    assign w_unused_cnt = '0;
    assign w_stall      = 1'b0;
    assign MduBusyE     = 1'b0;
    assign ALUResultE   = w_alu;
`endif

    assign StallReqE  = w_stall;
    assign RegWriteE  = r_RegWriteE & ~w_stall;
    assign MemWriteE  = r_MemWriteE & ~w_stall;
    assign RdE        = r_RdE;
    assign Rs1E       = r_Rs1E;
    assign Rs2E       = r_Rs2E;
    assign ResultSrcE = r_ResultSrcE;
    assign WriteDataE = w_wd;
endmodule

// File: tb/tb_stage_e_mdu.sv
// Self-checking bench for stage_e_mdu: random ALU/forwarding traffic and
// back-to-back MDU ops against an arithmetic reference model.
module tb_stage_e_mdu;
    localparam int XLEN = 32;
    localparam int REGW = 5;
    localparam int N    = 24;

    logic            clk = 1'b0;
    logic            rst;
    logic [XLEN-1:0] Rd1D, Rd2D, ImmExtD, ALUResultM, ResultW;
    logic [REGW-1:0] RdD, Rs1D, Rs2D;
    logic            RegWriteD, MemWriteD, ALUSrcD, SignedD, FlushE;
    logic [1:0]      ResultSrcD, ForwardAE, ForwardBE;
    logic [3:0]      OpD;
    logic [REGW-1:0] RdE, Rs1E, Rs2E;
    logic            RegWriteE, MemWriteE, StallReqE, MduBusyE;
    logic [1:0]      ResultSrcE;
    logic [XLEN-1:0] ALUResultE, WriteDataE;

    int checks = 0;
    int errors = 0;
    int cnt;
    logic            fl;
    logic [XLEN-1:0] e_res, e_op1, e_op2, e_wd;
    logic [3:0]      mop [N];
    logic [XLEN-1:0] ma [N];
    logic [XLEN-1:0] mb [N];
    logic            ms [N];

    always #5 clk = ~clk;

    stage_e_mdu #(.XLEN(XLEN), .REGW(REGW)) dut (
        .clk(clk), .rst(rst),
        .Rd1D(Rd1D), .Rd2D(Rd2D), .ImmExtD(ImmExtD),
        .RdD(RdD), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD),
        .ResultSrcD(ResultSrcD), .OpD(OpD), .SignedD(SignedD),
        .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ALUResultM(ALUResultM), .ResultW(ResultW),
        .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
        .StallReqE(StallReqE), .MduBusyE(MduBusyE)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [3:0] op,
                                           input logic [31:0] a, input logic [31:0] b,
                                           input logic sg);
        logic signed [63:0] sa, sb;
        logic [63:0] ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: return (a < b) ? 32'd1 : 32'd0;
            4'd7: return a << (b % 32);
            4'd8: return a >> (b % 32);
            4'd9: return $signed(a) >>> (b % 32);
            4'd10: begin p = ua * ub; return p[31:0]; end
            4'd11: begin p = sa * sb; return p[63:32]; end
            4'd12: begin p = ua * ub; return p[63:32]; end
            4'd13: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (!sg) return a / b;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return $signed(a) / $signed(b);
            end
            4'd14: begin
                if (b == 0) return a;
                if (!sg) return a % b;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return $signed(a) % $signed(b);
            end
            default: begin p = sa * $signed(ub); return p[63:32]; end
        endcase
    endfunction

    function automatic logic [31:0] fwd(input logic [1:0] s, input logic [31:0] r);
        case (s)
            2'b01:   return ResultW;
            2'b10:   return ALUResultM;
            default: return r;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom % 16;
            default: return $urandom;
        endcase
    endfunction

    task automatic d_nop();
        Rd1D = '0; Rd2D = '0; ImmExtD = '0; RdD = '0; Rs1D = '0; Rs2D = '0;
        RegWriteD = 1'b0; MemWriteD = 1'b0; ALUSrcD = 1'b0;
        ResultSrcD = '0; OpD = 4'd0; SignedD = 1'b0;
    endtask

    task automatic d_mdu(input int i);
        d_nop();
        OpD = mop[i]; Rd1D = ma[i]; Rd2D = mb[i]; SignedD = ms[i];
        RdD = REGW'(i + 1); RegWriteD = 1'b1; MemWriteD = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; FlushE = 1'b0; ForwardAE = '0; ForwardBE = '0;
        ALUResultM = '0; ResultW = '0;
        d_nop();
        #2 rst = 1'b0;
        #1;
        check("rst_alu", ALUResultE, 0);
        check("rst_wd", WriteDataE, 0);
        check("rst_stall", StallReqE, 0);
        check("rst_busy", MduBusyE, 0);
        check("rst_rw", RegWriteE, 0);
        check("rst_mw", MemWriteE, 0);
        check("rst_rd", RdE, 0);
        check("rst_rsrc", ResultSrcE, 0);
        tick(); tick();
        rst = 1'b1;

        // add 5 + 7
        Rd1D = 32'd5; Rd2D = 32'd7; RdD = 5'd3; RegWriteD = 1'b1;
        tick();
        check("add_res", ALUResultE, 12);
        check("add_stall", StallReqE, 0);
        check("add_rw", RegWriteE, 1);
        check("add_rd", RdE, 3);

        // sub with operand 1 forwarded from M
        OpD = 4'd1; Rd1D = 32'h55; Rd2D = 32'd1;
        tick();
        ForwardAE = 2'b10; ALUResultM = 32'h100;
        #1;
        check("fwd_sub", ALUResultE, 32'hFF);
        ForwardAE = 2'b00;

        for (int i = 0; i < 60; i++) begin
            OpD = 4'($urandom % 10); Rd1D = pick(); Rd2D = pick();
            ImmExtD = $urandom; ALUSrcD = 1'($urandom);
            RdD = REGW'($urandom); Rs1D = REGW'($urandom); Rs2D = REGW'($urandom);
            RegWriteD = 1'($urandom); MemWriteD = 1'($urandom);
            ResultSrcD = 2'($urandom); SignedD = 1'($urandom);
            ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
            ALUResultM = pick(); ResultW = pick();
            fl = ($urandom % 8) == 0;
            FlushE = fl;
            tick();
            FlushE = 1'b0;
            e_op1 = fwd(ForwardAE, fl ? 32'd0 : Rd1D);
            e_wd  = fwd(ForwardBE, fl ? 32'd0 : Rd2D);
            e_op2 = (!fl && ALUSrcD) ? ImmExtD : e_wd;
            e_res = ref_op(fl ? 4'd0 : OpD, e_op1, e_op2, 1'b0);
            check("alu_res", ALUResultE, e_res);
            check("alu_wd", WriteDataE, e_wd);
            check("alu_rd", RdE, fl ? 5'd0 : RdD);
            check("alu_rs1", Rs1E, fl ? 5'd0 : Rs1D);
            check("alu_rs2", Rs2E, fl ? 5'd0 : Rs2D);
            check("alu_rw", RegWriteE, fl ? 1'b0 : RegWriteD);
            check("alu_mw", MemWriteE, fl ? 1'b0 : MemWriteD);
            check("alu_rsrc", ResultSrcE, fl ? 2'd0 : ResultSrcD);
            check("alu_stall", StallReqE, 0);
        end
        ForwardAE = '0; ForwardBE = '0;

        mop[0] = 4'd12; ma[0] = 32'hFFFF_FFFF; mb[0] = 32'd2;          ms[0] = 1'b0;
        mop[1] = 4'd13; ma[1] = 32'hFFFF_FFF9; mb[1] = 32'd2;          ms[1] = 1'b1;
        mop[2] = 4'd14; ma[2] = 32'hFFFF_FFF9; mb[2] = 32'd2;          ms[2] = 1'b1;
        mop[3] = 4'd13; ma[3] = 32'd9;         mb[3] = 32'd0;          ms[3] = 1'b1;
        mop[4] = 4'd14; ma[4] = 32'd9;         mb[4] = 32'd0;          ms[4] = 1'b1;
        mop[5] = 4'd13; ma[5] = 32'h8000_0000; mb[5] = 32'hFFFF_FFFF; ms[5] = 1'b1;
        mop[6] = 4'd14; ma[6] = 32'h8000_0000; mb[6] = 32'hFFFF_FFFF; ms[6] = 1'b1;
        mop[7] = 4'd11; ma[7] = 32'h8000_0000; mb[7] = 32'h8000_0000; ms[7] = 1'b0;
        mop[8] = 4'd15; ma[8] = 32'hFFFF_FFFF; mb[8] = 32'hFFFF_FFFF; ms[8] = 1'b0;
        mop[9] = 4'd10; ma[9] = 32'h1234_5678; mb[9] = 32'd9;          ms[9] = 1'b0;
        for (int i = 10; i < N; i++) begin
            mop[i] = 4'(10 + $urandom % 6); ma[i] = pick(); mb[i] = pick();
            ms[i] = 1'($urandom);
        end

        d_mdu(0);
        tick();
        for (int i = 0; i < N; i++) begin
            if (i + 1 < N) d_mdu(i + 1);
            else d_nop();
            e_res = ref_op(mop[i], ma[i], mb[i], ms[i]);
`ifdef STAGE_E_MDU_EN
            check("mdu_idle_busy", MduBusyE, 0);
            cnt = 0;
            while (StallReqE === 1'b1 && cnt < 100) begin
                check("mdu_gate", {RegWriteE, MemWriteE}, 0);
                cnt++;
                tick();
                ForwardAE = 2'b01; ForwardBE = 2'b01;
                ResultW = $urandom; ALUResultM = $urandom;
            end
            check("mdu_stall_len", cnt, XLEN + 1);
            check("mdu_done_busy", MduBusyE, 1);
            check("mdu_result", ALUResultE, e_res);
            check("mdu_done_rw", RegWriteE, 1);
            ForwardAE = 2'b00; ForwardBE = 2'b00;
`else
            check("nomdu_stall", StallReqE, 0);
            check("nomdu_busy", MduBusyE, 0);
            check("nomdu_result", ALUResultE, 0);
            check("nomdu_rw", RegWriteE, 1);
`endif
            tick();
        end

`ifdef STAGE_E_MDU_EN
        // flush in the 10th BUSY cycle
        d_mdu(0);
        tick();
        d_nop();
        repeat (10) tick();
        check("fl_pre_busy", MduBusyE, 1);
        check("fl_pre_stall", StallReqE, 1);
        FlushE = 1'b1;
        tick();
        FlushE = 1'b0;
        check("fl_busy", MduBusyE, 0);
        check("fl_stall", StallReqE, 0);
        check("fl_rw", RegWriteE, 0);
        check("fl_alu", ALUResultE, 0);
        tick();
        check("fl_idle", MduBusyE, 0);
`endif

        // asynchronous reset in the 5th BUSY cycle
        d_mdu(9);
        tick();
        d_nop();
        repeat (5) tick();
        #2 rst = 1'b0;
        #1;
        check("rrst_alu", ALUResultE, 0);
        check("rrst_wd", WriteDataE, 0);
        check("rrst_stall", StallReqE, 0);
        check("rrst_busy", MduBusyE, 0);
        check("rrst_rw", RegWriteE, 0);
        check("rrst_mw", MemWriteE, 0);
        check("rrst_rd", RdE, 0);
        tick();
        rst = 1'b1;
        tick();
        check("post_busy", MduBusyE, 0);
        check("post_stall", StallReqE, 0);
        check("post_alu", ALUResultE, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
